// File: rtl/count_updn_bounded_pkg.sv
// count_pkg: bound-mode encodings and FSM state type shared by the bounded counter.
package count_pkg;
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    typedef enum logic {ST_RUN, ST_HALT} state_t;
endpackage

// File: rtl/count_updn_bounded_step_calc.sv
// count_step_calc: next counter value and bound events for one step.
module count_step_calc
    import count_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SWIDTH = 4
) (
    input  logic [WIDTH-1:0]  i_count,
    input  logic              i_dir,
    input  logic [SWIDTH-1:0] i_step,
    input  logic [WIDTH-1:0]  i_lo,
    input  logic [WIDTH-1:0]  i_hi,
    input  logic [1:0]        i_mode,
    output logic [WIDTH-1:0]  o_next_count,
    output logic              o_event_hi,
    output logic              o_event_lo
);
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_sat;
    logic [WIDTH-1:0] w_bound;

    assign w_step_ext = {{(WIDTH+1-SWIDTH){1'b0}}, i_step};
    assign w_sum      = {1'b0, i_count} + w_step_ext;
    assign w_diff     = {1'b0, i_count} - w_step_ext;
    assign o_event_hi = i_dir && (w_sum > {1'b0, i_hi});
    // MSB of the widened difference is the borrow out of the subtraction
    assign o_event_lo = !i_dir && (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < i_lo));
    assign w_sat      = (i_mode == MODE_SAT) || (i_mode == MODE_ONESHOT);
    assign w_bound    = (w_sat == i_dir) ? i_hi : i_lo;
    assign o_next_count = (o_event_hi || o_event_lo) ? w_bound :
                          i_dir ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
endmodule

// File: rtl/count_updn_bounded.sv
// count_updn_bounded: loadable up/down counter with programmable step and
// [lo,hi] bounds in wrap, saturate or one-shot mode, with sticky flags.
module count_updn_bounded
    import count_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SWIDTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic              i_dir,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_load_val,
    input  logic [SWIDTH-1:0] i_step,
    input  logic [WIDTH-1:0]  i_lo,
    input  logic [WIDTH-1:0]  i_hi,
    input  logic [1:0]        i_mode,
    input  logic              i_flag_clr,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_tc,
    output logic              o_ovf,
    output logic              o_unf,
    output logic              o_halted,
    output logic              o_cfg_err
);
    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_next_count;
    logic             w_event_hi;
    logic             w_event_lo;
    logic             w_step_go;
    logic             w_hit_hi;
    logic             w_hit_lo;

    count_step_calc #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) u_calc (
        .i_count      (r_count),
        .i_dir        (i_dir),
        .i_step       (i_step),
        .i_lo         (i_lo),
        .i_hi         (i_hi),
        .i_mode       (i_mode),
        .o_next_count (w_next_count),
        .o_event_hi   (w_event_hi),
        .o_event_lo   (w_event_lo)
    );

    assign o_cfg_err = i_lo > i_hi;
    assign w_step_go = i_en && !i_load && (r_state == ST_RUN) && !o_cfg_err && (i_step != '0);
    assign w_hit_hi  = w_step_go && w_event_hi;
    assign w_hit_lo  = w_step_go && w_event_lo;

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_RUN)
            w_next_state = ((w_hit_hi || w_hit_lo) && i_mode == MODE_ONESHOT) ? ST_HALT : ST_RUN;
        else
            w_next_state = i_load ? ST_RUN : ST_HALT;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= i_load ? i_load_val : w_step_go ? w_next_count : r_count;
            r_tc    <= w_hit_hi || w_hit_lo;
            // a same-cycle event overrides flag_clr
            r_ovf   <= (r_ovf && !i_flag_clr) || w_hit_hi;
            r_unf   <= (r_unf && !i_flag_clr) || w_hit_lo;
        end
    end

    assign o_count  = r_count;
    assign o_tc     = r_tc;
    assign o_ovf    = r_ovf;
    assign o_unf    = r_unf;
    assign o_halted = (r_state == ST_HALT);
endmodule

// File: tb/tb_count_updn_bounded.sv
// tb_count_updn_bounded: directed stimulus checked every cycle against an
// integer-arithmetic reference model, plus hand-computed literal checkpoints.
module tb_count_updn_bounded;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, dir = 1'b0, load = 1'b0, flag_clr = 1'b0;
    logic [7:0] load_val = '0, lo = '0, hi = '0;
    logic [3:0] step = '0;
    logic [1:0] mode = '0;
    logic [7:0] count;
    logic       tc, ovf, unf, halted, cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    count_updn_bounded #(.WIDTH(8), .SWIDTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (en),
        .i_dir      (dir),
        .i_load     (load),
        .i_load_val (load_val),
        .i_step     (step),
        .i_lo       (lo),
        .i_hi       (hi),
        .i_mode     (mode),
        .i_flag_clr (flag_clr),
        .o_count    (count),
        .o_tc       (tc),
        .o_ovf      (ovf),
        .o_unf      (unf),
        .o_halted   (halted),
        .o_cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain signed integer arithmetic on the bound rules
    int m_count, m_tc, m_ovf, m_unf, m_halt;
    int nxt, go, ev, sat;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_count <= 0; m_tc <= 0; m_ovf <= 0; m_unf <= 0; m_halt <= 0;
        end else begin
            go  = int'(en && !load && m_halt == 0 && lo <= hi && step != 0);
            nxt = dir ? m_count + int'(step) : m_count - int'(step);
            ev  = go != 0 && (dir ? nxt > int'(hi) : nxt < int'(lo));
            sat = int'(mode == 2'd1 || mode == 2'd2);
            m_tc <= ev;
            if (load) begin
                m_count <= int'(load_val);
                m_halt  <= 0;
            end else if (go != 0) begin
                if (ev == 0) m_count <= nxt;
                else if (sat != 0) m_count <= dir ? int'(hi) : int'(lo);
                else m_count <= dir ? int'(lo) : int'(hi);
                if (ev != 0 && mode == 2'd2) m_halt <= 1;
            end
            m_ovf <= int'((m_ovf != 0 && !flag_clr) || (ev != 0 && dir));
            m_unf <= int'((m_unf != 0 && !flag_clr) || (ev != 0 && !dir));
        end
    end

    always @(posedge clk) begin
        #1;
        chk("count",   int'(count),   m_count);
        chk("tc",      int'(tc),      m_tc);
        chk("ovf",     int'(ovf),     m_ovf);
        chk("unf",     int'(unf),     m_unf);
        chk("halted",  int'(halted),  m_halt);
        chk("cfg_err", int'(cfg_err), int'(lo > hi));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12 rstn = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_halted", int'(halted), 0);
        lo = 0; hi = 255; mode = 0; dir = 1; step = 1; en = 1;
        tick(3);
        chk("t1_count", int'(count), 3);
        chk("t1_tc", int'(tc), 0);

        en = 0; lo = 10; hi = 20; load = 1; load_val = 18; step = 3;
        tick();
        load = 0; en = 1;
        tick();
        chk("t2_wrap_count", int'(count), 10);
        chk("t2_wrap_tc", int'(tc), 1);
        chk("t2_ovf", int'(ovf), 1);
        load = 1; load_val = 13; dir = 0;
        tick();
        load = 0;
        tick();
        chk("t2_land_lo", int'(count), 10);
        chk("t2_land_unf", int'(unf), 0);
        tick();
        chk("t2_wrap_dn", int'(count), 20);
        chk("t2_wrap_dn_unf", int'(unf), 1);

        mode = 1; load = 1; load_val = 19; step = 1; dir = 1;
        tick();
        load = 0;
        tick();
        chk("t3_land_hi_tc", int'(tc), 0);
        tick(2);
        chk("t3_sat_count", int'(count), 20);
        chk("t3_sat_tc", int'(tc), 1);
        en = 0; flag_clr = 1;
        tick();
        chk("t3_clr_ovf", int'(ovf), 0);
        flag_clr = 0;

        mode = 2; lo = 5; load = 1; load_val = 7; step = 2; dir = 0;
        tick();
        load = 0; en = 1;
        tick(2);
        chk("t4_halt", int'(halted), 1);
        chk("t4_count", int'(count), 5);
        tick(4);
        mode = 0;
        tick();
        chk("t4_held", int'(count), 5);
        chk("t4_still_halt", int'(halted), 1);
        load = 1; load_val = 9;
        tick();
        chk("t4_reload", int'(count), 9);
        chk("t4_unhalt", int'(halted), 0);

        lo = 0; hi = 50; dir = 1; step = 1; load_val = 200;
        tick();
        chk("t5_load_wins", int'(count), 200);
        load = 0;
        tick();
        chk("t5_wrap", int'(count), 0);
        chk("t5_ovf", int'(ovf), 1);
        load = 1; load_val = 50;
        tick();
        load = 0; flag_clr = 1;
        tick();
        chk("t5_set_wins", int'(ovf), 1);
        flag_clr = 0;
        tick(2);

        lo = 30; hi = 10;
        #1 chk("t6_cfg_err", int'(cfg_err), 1);
        tick(2);
        chk("t6_hold", int'(count), 2);
        #3 rstn = 1'b0;
        #1;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_ovf", int'(ovf), 0);
        chk("t6_rst_tc", int'(tc), 0);
        #10 rstn = 1'b1;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
